// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch state encoding and the
// opcode length decode used by both instruction fetch and the control unit.
package cpu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_MOV_RA = 8'h04;
  localparam logic [7:0] OP_MOV_AR = 8'h05;
  localparam logic [7:0] OP_MOV_IR = 8'h06;
  localparam logic [7:0] OP_JMP    = 8'h07;
  localparam logic [7:0] OP_CLR    = 8'h12;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_A    = 2'd1,
    S_B    = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [1:0] len;
    logic       illegal;
  } op_info_t;

  // Unknown opcodes are treated as single-byte so fetch never stalls on them.
  function automatic op_info_t op_len(input logic [7:0] op);
    op_info_t info;
    info.len     = 2'd1;
    info.illegal = 1'b0;
    case (op)
      OP_NOP, OP_CLR:                  info.len = 2'd1;
      OP_ADD, OP_SUB, OP_JMP:          info.len = 2'd2;
      OP_MOV_RA, OP_MOV_AR, OP_MOV_IR: info.len = 2'd3;
      default:                         info.illegal = 1'b1;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Program-memory reader: walks the PC one byte per cycle, assembles a
// 1-3 byte instruction and hands it to the control unit over valid/ready.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pm_addr,
  input  logic [DATA_W-1:0] pm_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              illegal
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  op_info_t          dec;
  logic              ld_op;
  logic              ld_a;
  logic              ld_b;

  assign dec     = op_len(pm_data);
  assign pm_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_OP:    state_next = (dec.len >= 2'd2) ? S_A : S_HOLD;
      S_A:     state_next = (instr_len == 2'd3) ? S_B : S_HOLD;
      S_B:     state_next = S_HOLD;
      S_HOLD:  state_next = instr_ready ? S_OP : S_HOLD;
      default: state_next = S_OP;
    endcase
  end

  always_comb begin
    ld_op = 1'b0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    case (state)
      S_OP:    ld_op = 1'b1;
      S_A:     ld_a  = 1'b1;
      S_B:     ld_b  = 1'b1;
      default: ;
    endcase
  end

  // JMP retargets the PC on the same edge that captures its operand, so the
  // fetch after the handshake already reads from the jump target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      opcode      <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      instr_len   <= 2'd1;
      instr_pc    <= RESET_PC;
      illegal     <= 1'b0;
    end else begin
      instr_valid <= (state_next == S_HOLD);
      if (ld_op) begin
        opcode    <= pm_data;
        instr_pc  <= pc;
        operand_a <= '0;
        operand_b <= '0;
        instr_len <= dec.len;
        illegal   <= dec.illegal;
        pc        <= pc + ADDR_W'(1);
      end
      if (ld_a) begin
        operand_a <= pm_data;
        pc        <= (opcode == OP_JMP) ? ADDR_W'(pm_data) : pc + ADDR_W'(1);
      end
      if (ld_b) begin
        operand_b <= pm_data;
        pc        <= pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Reader side of the 8-bit program memory: drives the byte address, collects the variable-length instruction (opcode plus 0-2 operand bytes) one byte per cycle, and presents the assembled instruction to decode/execute over a valid/ready handshake. It owns the program counter (PC) and resolves unconditional JMP locally by reloading the PC. It sits between the program memory (combinational read) and the control unit.

Parameters:
ADDR_W, 8, program address / PC width
DATA_W, 8, instruction byte width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pm_addr  output  ADDR_W  byte address to program memory; equals PC, combinational from PC
pm_data  input  DATA_W  byte returned by program memory, valid in the same cycle as pm_addr
instr_valid  output  1  assembled instruction available
instr_ready  input  1  consumer accepts the instruction this cycle
opcode  output  DATA_W  opcode byte
operand_a  output  DATA_W  first operand byte (0 if none)
operand_b  output  DATA_W  second operand byte (0 if none)
instr_len  output  2  byte count of the instruction, 1..3
instr_pc  output  ADDR_W  address of the opcode byte
illegal  output  1  opcode not in the table; qualified by instr_valid

Behaviour:
- Reset (async, immediate): PC=RESET_PC, state=S_OP. instr_valid=0, illegal=0, opcode/operand_a/operand_b=0, instr_len=1, instr_pc=RESET_PC.
- Length table: NOP 0x00=1; ADD 0x01=2; SUB 0x02=2; MOV reg->addr 0x04=3; MOV addr->reg 0x05=3; MOV imm->reg 0x06=3; JMP 0x07=2; CLR 0x12=1. Any other opcode has length 1 and sets illegal=1.
- The state machine reads one byte per cycle. Its states are S_OP, S_A, S_B and S_HOLD.
- S_OP: latch opcode=pm_data and instr_pc=PC. Clear both operands, set instr_len and illegal, PC+=1. Then go to S_A if len>=2, else S_HOLD.
- S_A: latch operand_a=pm_data, PC+=1. Then go to S_B if len==3, else S_HOLD.
- S_B: latch operand_b=pm_data, PC+=1, go to S_HOLD.
- S_HOLD: instr_valid=1. All instruction outputs and PC stay stable while instr_ready=0.
  - On instr_valid&&instr_ready: go to S_OP and drop instr_valid the next cycle.
  - If the opcode is JMP, PC is loaded with operand_a on entry to S_HOLD, i.e. the same edge that captures the operand. The JMP itself is still presented to the consumer.
- Latency: an instruction of length N is valid N cycles after its S_OP cycle. Throughput is N+1 cycles per instruction when instr_ready is held at 1.
- PC arithmetic is modulo 2^ADDR_W. 0xFF+1 wraps to 0x00, including in the middle of an instruction: operands are read from 0x00, 0x01.
- The PC never changes while instr_valid=1, so pm_addr is stable during a stall.
- instr_ready while instr_valid=0 is ignored.
- Reset asserted mid-instruction discards the partial instruction. Fetch restarts at RESET_PC in the first cycle after deassertion.
- All outputs except pm_addr are registered.

Decomposition:
- Package cpu_pkg:
  - opcode constants: OP_NOP, OP_ADD, OP_SUB, OP_MOV_RA, OP_MOV_AR, OP_MOV_IR, OP_JMP, OP_CLR
  - fetch state enum: S_OP, S_A, S_B, S_HOLD
  - function op_len(opcode) returning {len, illegal}
- No sub-module is required. The length decode is a pure function in the package so the control unit reuses it.

Test Plan:
- Memory preloaded 05 07 02, instr_ready=1 -> valid on cycle 3 with opcode=05, operand_a=07, operand_b=02, instr_len=3, instr_pc=00; next opcode is fetched from 03.
- Bytes 01 03 12 -> ADD with operand_a=03, len=2, operand_b=00; then CLR with len=1, instr_pc=02, operands=0.
- JMP 07 21 at 12h -> instruction presented with operand_a=21; the next S_OP reads pm_addr=21h; instr_pc of the next instruction is 21h.
- instr_ready=0 for 5 cycles while valid -> outputs and pm_addr are constant; one cycle of instr_ready=1 completes the handshake and the next fetch starts the following cycle.
- 3-byte opcode at FEh -> operands read from FFh and 00h; the next opcode is fetched from 01h.
- Opcode 0xAA -> illegal=1 with len=1 and PC advances by 1; separately, rst pulsed during S_A -> instr_valid=0 and pm_addr=RESET_PC immediately, and fetch restarts cleanly.
